// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory read handshake,
// tracks PC and redirects, and feeds the IF/ID pipeline register.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic [15:0] Target,
  input  logic        Stall,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_rdy,
  output logic [15:0] IF_ID_Instr,
  output logic [15:0] IF_ID_PCInc,
  output logic        IF_ID_Valid,
  output logic        Halted
);

  typedef enum logic [2:0] {
    ST_FETCH, ST_WAIT, ST_DRAIN, ST_HOLD, ST_HALT
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] pend_target, pend_n;
  logic [15:0] hold_reg, hold_n;
  logic [15:0] instr_n, pcinc_n;
  logic        valid_n;
  logic [15:0] pc_inc;
  logic        do_accept, do_bubble;
  logic [15:0] acc_word;

  assign pc_inc    = pc + 16'd2;
  assign imem_addr = pc;
  assign Halted    = (state == ST_HALT);

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_n    = pend_target;
    hold_n    = hold_reg;
    instr_n   = IF_ID_Instr;
    pcinc_n   = IF_ID_PCInc;
    valid_n   = IF_ID_Valid;
    imem_rd   = 1'b0;
    do_accept = 1'b0;
    do_bubble = 1'b0;
    acc_word  = imem_data;

    case (state)
      ST_FETCH: begin
        imem_rd = ~Stall & ~PCSrc;
        if (PCSrc) begin
          pc_n      = Target;
          do_bubble = 1'b1;
        end else if (!Stall) begin
          if (imem_rdy) do_accept = 1'b1;
          else begin
            do_bubble = 1'b1;
            state_n   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        imem_rd = 1'b1;
        if (PCSrc) begin
          do_bubble = 1'b1;
          if (imem_rdy) begin
            pc_n    = Target;
            state_n = ST_FETCH;
          end else begin
            pend_n  = Target;
            state_n = ST_DRAIN;
          end
        end else if (Stall) begin
          // Word arrived while decode is stalled: park it so the bus is released.
          if (imem_rdy) begin
            hold_n  = imem_data;
            state_n = ST_HOLD;
          end
        end else if (imem_rdy) begin
          do_accept = 1'b1;
        end else begin
          do_bubble = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Outstanding read must finish at the old address before redirecting.
        imem_rd   = 1'b1;
        do_bubble = ~Stall | PCSrc;
        if (PCSrc) pend_n = Target;
        if (imem_rdy) begin
          pc_n    = PCSrc ? Target : pend_target;
          state_n = ST_FETCH;
        end
      end
      ST_HOLD: begin
        acc_word = hold_reg;
        if (PCSrc) begin
          pc_n      = Target;
          do_bubble = 1'b1;
          state_n   = ST_FETCH;
        end else if (!Stall) begin
          do_accept = 1'b1;
        end
      end
      ST_HALT: begin
        do_bubble = ~Stall;
      end
      default: state_n = ST_FETCH;
    endcase

    if (do_bubble) begin
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
    end
    if (do_accept) begin
      instr_n = acc_word;
      pcinc_n = pc_inc;
      valid_n = 1'b1;
      if (acc_word[15:11] == 5'b00000) begin
        state_n = ST_HALT;
      end else begin
        pc_n    = pc_inc;
        state_n = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      pend_target <= 16'h0000;
      hold_reg    <= 16'h0000;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_PCInc <= 16'h0000;
      IF_ID_Valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_target <= pend_n;
      hold_reg    <= hold_n;
      IF_ID_Instr <= instr_n;
      IF_ID_PCInc <= pcinc_n;
      IF_ID_Valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: fixed-latency memory model with bench-driven
// ready, hand-computed IF/ID and PC expectations per scenario.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrc = 1'b0;
  logic [15:0] Target = 16'h0000;
  logic        Stall = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_rdy = 1'b0;
  logic [15:0] IF_ID_Instr;
  logic [15:0] IF_ID_PCInc;
  logic        IF_ID_Valid;
  logic        Halted;

  logic [15:0] mem [0:255];
  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .Target(Target), .Stall(Stall),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .imem_rdy(imem_rdy), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCInc(IF_ID_PCInc),
    .IF_ID_Valid(IF_ID_Valid), .Halted(Halted)
  );

  always #5 clk = ~clk;

  always_comb imem_data = mem[imem_addr[8:1]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", IF_ID_Valid); end
    n_cmp++; if (IF_ID_Instr !== 16'h0800) begin n_err++; $display("FAIL rst_instr got %h exp 0800", IF_ID_Instr); end
    n_cmp++; if (IF_ID_PCInc !== 16'h0000) begin n_err++; $display("FAIL rst_pcinc got %h exp 0000", IF_ID_PCInc); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr got %h exp 0000", imem_addr); end
    n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %b exp 0", Halted); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    imem_rdy = 1'b1;
    #1;
    n_cmp++; if (imem_rd !== 1'b1) begin n_err++; $display("FAIL zw_rd got %b exp 1", imem_rd); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL zw_addr0 got %h exp 0000", imem_addr); end
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h1111) begin n_err++; $display("FAIL zw_instr0 got %h exp 1111", IF_ID_Instr); end
    n_cmp++; if (IF_ID_PCInc !== 16'h0002) begin n_err++; $display("FAIL zw_pcinc0 got %h exp 0002", IF_ID_PCInc); end
    n_cmp++; if (IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL zw_valid0 got %b exp 1", IF_ID_Valid); end
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h2222) begin n_err++; $display("FAIL zw_instr1 got %h exp 2222", IF_ID_Instr); end
    n_cmp++; if (IF_ID_PCInc !== 16'h0004) begin n_err++; $display("FAIL zw_pcinc1 got %h exp 0004", IF_ID_PCInc); end
    n_cmp++; if (IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL zw_valid1 got %b exp 1", IF_ID_Valid); end
  endtask

  task automatic test_wait_states();
    PCSrc = 1'b1; Target = 16'h0010;
    tick();
    n_cmp++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 16'h0800) begin n_err++; $display("FAIL redir_bubble got %b/%h exp 0/0800", IF_ID_Valid, IF_ID_Instr); end
    n_cmp++; if (IF_ID_PCInc !== 16'h0004) begin n_err++; $display("FAIL redir_pcinc got %h exp 0004", IF_ID_PCInc); end
    n_cmp++; if (imem_addr !== 16'h0010) begin n_err++; $display("FAIL redir_addr got %h exp 0010", imem_addr); end
    PCSrc = 1'b0; imem_rdy = 1'b0;
    tick();
    n_cmp++; if (IF_ID_Valid !== 1'b0 || imem_addr !== 16'h0010) begin n_err++; $display("FAIL wait1 got %b/%h exp 0/0010", IF_ID_Valid, imem_addr); end
    n_cmp++; if (imem_rd !== 1'b1) begin n_err++; $display("FAIL wait_rd got %b exp 1", imem_rd); end
    tick();
    n_cmp++; if (IF_ID_Valid !== 1'b0 || imem_addr !== 16'h0010) begin n_err++; $display("FAIL wait2 got %b/%h exp 0/0010", IF_ID_Valid, imem_addr); end
    imem_rdy = 1'b1;
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h3333 || IF_ID_PCInc !== 16'h0012 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL wait_accept got %h/%h/%b exp 3333/0012/1", IF_ID_Instr, IF_ID_PCInc, IF_ID_Valid); end
  endtask

  task automatic test_drain();
    imem_rdy = 1'b0;
    tick();
    PCSrc = 1'b1; Target = 16'h0040;
    tick();
    n_cmp++; if (imem_addr !== 16'h0012 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL drain_enter got %h/%b exp 0012/0", imem_addr, IF_ID_Valid); end
    PCSrc = 1'b0;
    #1;
    n_cmp++; if (imem_rd !== 1'b1) begin n_err++; $display("FAIL drain_rd got %b exp 1", imem_rd); end
    tick();
    n_cmp++; if (imem_addr !== 16'h0012 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL drain_hold got %h/%b exp 0012/0", imem_addr, IF_ID_Valid); end
    imem_rdy = 1'b1;
    tick();
    n_cmp++; if (imem_addr !== 16'h0040 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL drain_exit got %h/%b exp 0040/0", imem_addr, IF_ID_Valid); end
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h5555 || IF_ID_PCInc !== 16'h0042 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL drain_next got %h/%h/%b exp 5555/0042/1", IF_ID_Instr, IF_ID_PCInc, IF_ID_Valid); end
  endtask

  task automatic test_hold();
    imem_rdy = 1'b0;
    tick();
    Stall = 1'b1; imem_rdy = 1'b1;
    tick();
    n_cmp++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 16'h0800 || IF_ID_PCInc !== 16'h0042) begin n_err++; $display("FAIL hold_enter got %b/%h/%h exp 0/0800/0042", IF_ID_Valid, IF_ID_Instr, IF_ID_PCInc); end
    n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL hold_rd got %b exp 0", imem_rd); end
    mem[8'h21] = 16'h7777;
    tick();
    n_cmp++; if (IF_ID_Valid !== 1'b0 || imem_addr !== 16'h0042) begin n_err++; $display("FAIL hold_stay got %b/%h exp 0/0042", IF_ID_Valid, imem_addr); end
    Stall = 1'b0;
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h6666 || IF_ID_PCInc !== 16'h0044 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL hold_accept got %h/%h/%b exp 6666/0044/1", IF_ID_Instr, IF_ID_PCInc, IF_ID_Valid); end
    n_cmp++; if (imem_addr !== 16'h0044) begin n_err++; $display("FAIL hold_pc got %h exp 0044", imem_addr); end
  endtask

  task automatic test_stall_fetch();
    Stall = 1'b1;
    #1;
    n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL stall_rd got %b exp 0", imem_rd); end
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h6666 || IF_ID_Valid !== 1'b1 || imem_addr !== 16'h0044) begin n_err++; $display("FAIL stall_hold got %h/%b/%h exp 6666/1/0044", IF_ID_Instr, IF_ID_Valid, imem_addr); end
    Stall = 1'b0;
  endtask

  task automatic test_halt();
    PCSrc = 1'b1; Target = 16'h0020;
    tick();
    PCSrc = 1'b0;
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h0000 || IF_ID_Valid !== 1'b1 || IF_ID_PCInc !== 16'h0022) begin n_err++; $display("FAIL halt_accept got %h/%b/%h exp 0000/1/0022", IF_ID_Instr, IF_ID_Valid, IF_ID_PCInc); end
    n_cmp++; if (Halted !== 1'b1 || imem_addr !== 16'h0020) begin n_err++; $display("FAIL halt_state got %b/%h exp 1/0020", Halted, imem_addr); end
    PCSrc = 1'b1; Target = 16'h0080;
    #1;
    n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL halt_rd got %b exp 0", imem_rd); end
    tick();
    n_cmp++; if (imem_addr !== 16'h0020 || Halted !== 1'b1 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL halt_ignore got %h/%b/%b exp 0020/1/0", imem_addr, Halted, IF_ID_Valid); end
    PCSrc = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_addr !== 16'h0000 || Halted !== 1'b0) begin n_err++; $display("FAIL halt_rst got %h/%b exp 0000/0", imem_addr, Halted); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    PCSrc = 1'b1; Target = 16'h0030;
    tick();
    PCSrc = 1'b0; imem_rdy = 1'b0;
    tick();
    n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0030) begin n_err++; $display("FAIL mid_wait got %b/%h exp 1/0030", imem_rd, imem_addr); end
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_addr !== 16'h0000 || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL mid_rst got %h/%b exp 0000/0", imem_addr, IF_ID_Valid); end
    tick();
    rst = 1'b0; imem_rdy = 1'b1;
    #1;
    n_cmp++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL mid_req got %b/%h exp 1/0000", imem_rd, imem_addr); end
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h1111 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL mid_accept got %h/%b exp 1111/1", IF_ID_Instr, IF_ID_Valid); end
  endtask

  task automatic test_wrap();
    PCSrc = 1'b1; Stall = 1'b1; Target = 16'hFFFE;
    #1;
    n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL wrap_rd got %b exp 0", imem_rd); end
    tick();
    n_cmp++; if (imem_addr !== 16'hFFFE || IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL wrap_redir got %h/%b exp FFFE/0", imem_addr, IF_ID_Valid); end
    PCSrc = 1'b0; Stall = 1'b0;
    tick();
    n_cmp++; if (IF_ID_Instr !== 16'h9999 || IF_ID_PCInc !== 16'h0000 || IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL wrap_accept got %h/%h/%b exp 9999/0000/1", IF_ID_Instr, IF_ID_PCInc, IF_ID_Valid); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_pc got %h exp 0000", imem_addr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0800;
    mem[8'h00] = 16'h1111;
    mem[8'h01] = 16'h2222;
    mem[8'h08] = 16'h3333;
    mem[8'h09] = 16'h4444;
    mem[8'h20] = 16'h5555;
    mem[8'h21] = 16'h6666;
    mem[8'h10] = 16'h0000;
    mem[8'hFF] = 16'h9999;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_drain();
    test_hold();
    test_stall_fetch();
    test_halt();
    test_reset_mid_read();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
